// File: rtl/ccip_interface_pipe.sv
// Multi-channel CCI-P register slice: pipelined Tx paths with per-channel skid FIFOs and
// almost-full credit, sticky overflow flags, a delayed Rx path and a stretched AFU soft reset.
module ccip_interface_pipe #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned RX_W       = 16,
    parameter int unsigned TX_STAGES  = 2,
    parameter int unsigned RX_STAGES  = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AFU_SLACK  = 8,
    parameter int unsigned RST_HOLD   = 4
) (
    input  logic                     pClk,
    input  logic                     pck_cp2af_softReset_n,
    input  logic [NUM_CH-1:0]        af_valid,
    input  logic [NUM_CH*DATA_W-1:0] af_data,
    output logic [NUM_CH-1:0]        af_almFull,
    output logic [NUM_CH-1:0]        fiu_valid,
    output logic [NUM_CH*DATA_W-1:0] fiu_data,
    input  logic [NUM_CH-1:0]        fiu_almFull,
    input  logic                     rx_valid_in,
    input  logic [RX_W-1:0]          rx_data_in,
    output logic                     rx_valid_out,
    output logic [RX_W-1:0]          rx_data_out,
    output logic [NUM_CH-1:0]        ovf_err,
    output logic                     softReset_n_out
);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + TX_STAGES + 1);
    localparam int unsigned THRESH = FIFO_DEPTH - AFU_SLACK - 1;
    localparam int unsigned TS     = (TX_STAGES > 0) ? TX_STAGES : 1;
    localparam int unsigned HOLD_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

    if (FIFO_DEPTH < AFU_SLACK + TX_STAGES + 2) begin : g_bad_depth
        $error("FIFO_DEPTH too small for AFU_SLACK + TX_STAGES + 2");
    end
    if (RX_STAGES < 1) begin : g_bad_rx
        $error("RX_STAGES must be at least 1");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic              wr_v;
        logic [DATA_W-1:0] wr_d;
        logic [OCC_W-1:0]  stg_cnt;
        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  rd_ptr, wr_ptr;
        logic [CNT_W-1:0]  count;
        logic              empty, full, pop, accept;
        logic [OCC_W-1:0]  occ;
        logic              fv_q, afull_q, ovf_q;
        logic [DATA_W-1:0] fd_q;

        if (TX_STAGES > 0) begin : g_stg
            logic [TS-1:0]     stg_v;
            logic [DATA_W-1:0] stg_d [TS];

            always_ff @(posedge pClk) begin
                if (!pck_cp2af_softReset_n) begin
                    stg_v <= '0;
                end else begin
                    stg_v[0] <= af_valid[c];
                    for (int unsigned s = 1; s < TS; s++) stg_v[s] <= stg_v[s-1];
                end
            end

            always_ff @(posedge pClk) begin
                stg_d[0] <= af_data[c*DATA_W +: DATA_W];
                for (int unsigned s = 1; s < TS; s++) stg_d[s] <= stg_d[s-1];
            end

            always_comb begin
                stg_cnt = '0;
                for (int unsigned s = 0; s < TS; s++) stg_cnt = stg_cnt + OCC_W'(stg_v[s]);
            end

            assign wr_v = stg_v[TS-1];
            assign wr_d = stg_d[TS-1];
        end else begin : g_nostg
            assign stg_cnt = '0;
            assign wr_v    = af_valid[c];
            assign wr_d    = af_data[c*DATA_W +: DATA_W];
        end

        assign empty  = (count == '0);
        assign full   = (count == CNT_W'(FIFO_DEPTH));
        assign pop    = !empty && !fiu_almFull[c];
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        assign accept = wr_v && (!full || pop);
        assign occ    = OCC_W'(count) + stg_cnt;

        always_ff @(posedge pClk) begin
            if (!pck_cp2af_softReset_n) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                fv_q    <= 1'b0;
                afull_q <= 1'b1;
                ovf_q   <= 1'b0;
            end else begin
                if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count   <= count + CNT_W'(accept) - CNT_W'(pop);
                fv_q    <= pop;
                afull_q <= (occ >= OCC_W'(THRESH));
                if (wr_v && !accept) ovf_q <= 1'b1;
            end
        end

        always_ff @(posedge pClk) begin
            if (accept) mem[wr_ptr] <= wr_d;
            if (pop) fd_q <= mem[rd_ptr];
        end

        assign fiu_valid[c]                 = fv_q;
        assign fiu_data[c*DATA_W +: DATA_W] = fd_q;
        assign af_almFull[c]                = afull_q;
        assign ovf_err[c]                   = ovf_q;
    end

    logic [RX_STAGES-1:0] rx_v;
    logic [RX_W-1:0]      rx_d [RX_STAGES];

    always_ff @(posedge pClk) begin
        if (!pck_cp2af_softReset_n) begin
            rx_v <= '0;
        end else begin
            rx_v[0] <= rx_valid_in;
            for (int unsigned s = 1; s < RX_STAGES; s++) rx_v[s] <= rx_v[s-1];
        end
    end

    always_ff @(posedge pClk) begin
        rx_d[0] <= rx_data_in;
        for (int unsigned s = 1; s < RX_STAGES; s++) rx_d[s] <= rx_d[s-1];
    end

    assign rx_valid_out = rx_v[RX_STAGES-1];
    assign rx_data_out  = rx_d[RX_STAGES-1];

    logic [HOLD_W-1:0] hold_cnt;
    logic              srst_q;

    always_ff @(posedge pClk) begin
        if (!pck_cp2af_softReset_n) begin
            hold_cnt <= HOLD_W'(RST_HOLD);
            srst_q   <= 1'b0;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
            srst_q   <= 1'b0;
        end else begin
            srst_q   <= 1'b1;
        end
    end

    assign softReset_n_out = srst_q;
endmodule

// File: tb/tb_ccip_interface_pipe.sv
// Directed self-checking bench for ccip_interface_pipe using default parameters.
module tb_ccip_interface_pipe;
    logic        pClk;
    logic        rst_n;
    logic [1:0]  af_valid;
    logic [31:0] af_data;
    logic [1:0]  af_almFull;
    logic [1:0]  fiu_valid;
    logic [31:0] fiu_data;
    logic [1:0]  fiu_almFull;
    logic        rx_valid_in;
    logic [15:0] rx_data_in;
    logic        rx_valid_out;
    logic [15:0] rx_data_out;
    logic [1:0]  ovf_err;
    logic        softReset_n_out;

    int n_assert = 0;
    int n_fail   = 0;

    ccip_interface_pipe #(
        .NUM_CH(2), .DATA_W(16), .RX_W(16), .TX_STAGES(2), .RX_STAGES(2),
        .FIFO_DEPTH(16), .AFU_SLACK(8), .RST_HOLD(4)
    ) dut (
        .pClk(pClk),
        .pck_cp2af_softReset_n(rst_n),
        .af_valid(af_valid),
        .af_data(af_data),
        .af_almFull(af_almFull),
        .fiu_valid(fiu_valid),
        .fiu_data(fiu_data),
        .fiu_almFull(fiu_almFull),
        .rx_valid_in(rx_valid_in),
        .rx_data_in(rx_data_in),
        .rx_valid_out(rx_valid_out),
        .rx_data_out(rx_data_out),
        .ovf_err(ovf_err),
        .softReset_n_out(softReset_n_out)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int issued, extra, rise_at, got;
        bit seen;

        rst_n = 1'b0; af_valid = '0; af_data = '0; fiu_almFull = '0;
        rx_valid_in = 1'b0; rx_data_in = '0;

        // Reset state
        tick(); tick();
        chk("rst_fiu_valid", 32'(fiu_valid), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid_out), 32'h0);
        chk("rst_ovf", 32'(ovf_err), 32'h0);
        chk("rst_almfull", 32'(af_almFull), 32'h3);
        chk("rst_srst", 32'(softReset_n_out), 32'h0);

        // Release: almFull drops at first edge, soft reset rises after RST_HOLD+1 edges
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) chk("rel_almfull", 32'(af_almFull), 32'h0);
            chk("rel_srst", 32'(softReset_n_out), 32'(k == 5));
        end

        // Latency: single request on ch0 appears 4 cycles later, ch1 idle
        af_valid = 2'b01; af_data[15:0] = 16'h1234;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) af_valid = '0;
            chk("lat_v0", 32'(fiu_valid[0]), 32'(k == 4));
            chk("lat_v1", 32'(fiu_valid[1]), 32'h0);
            if (k == 4) chk("lat_data", 32'(fiu_data[15:0]), 32'h1234);
        end

        // Credit: ch1 blocked, AFU stops AFU_SLACK requests after seeing almFull
        fiu_almFull = 2'b10;
        issued = 0; extra = 0; rise_at = -1; seen = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (!seen && af_almFull[1]) begin seen = 1'b1; rise_at = issued; end
            if (seen && extra == 8) break;
            af_valid = 2'b10; af_data[31:16] = 16'(16'h0100 + issued);
            issued++;
            if (seen) extra++;
            tick();
        end
        af_valid = '0;
        chk("cred_rise_at", 32'(rise_at), 32'd8);
        chk("cred_issued", 32'(issued), 32'd16);
        for (int k = 0; k < 4; k++) tick();
        chk("cred_held", 32'(fiu_valid), 32'h0);
        chk("cred_almfull", 32'(af_almFull[1]), 32'h1);
        chk("cred_ovf", 32'(ovf_err), 32'h0);
        fiu_almFull = 2'b00;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("cred_drain_v", 32'(fiu_valid[1]), 32'h1);
            chk("cred_drain_d", 32'(fiu_data[31:16]), 32'h0100 + 32'(i));
        end
        tick();
        chk("cred_done", 32'(fiu_valid), 32'h0);

        // Overflow: 17 writes into blocked ch1, 17th dropped
        fiu_almFull = 2'b10;
        for (int i = 0; i < 17; i++) begin
            af_valid = 2'b10; af_data[31:16] = 16'(16'h0200 + i);
            tick();
        end
        af_valid = '0;
        for (int k = 0; k < 4; k++) tick();
        chk("ovf_set", 32'(ovf_err), 32'h2);
        fiu_almFull = 2'b00;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("ovf_drain_v", 32'(fiu_valid[1]), 32'h1);
            chk("ovf_drain_d", 32'(fiu_data[31:16]), 32'h0200 + 32'(i));
        end
        tick();
        chk("ovf_no17", 32'(fiu_valid), 32'h0);
        chk("ovf_sticky", 32'(ovf_err), 32'h2);

        // Reset mid-operation with 5 entries queued on ch0
        fiu_almFull = 2'b01;
        for (int i = 0; i < 5; i++) begin
            af_valid = 2'b01; af_data[15:0] = 16'(16'h0300 + i);
            tick();
        end
        af_valid = '0;
        tick(); tick(); tick();
        chk("mid_almfull_pre", 32'(af_almFull), 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        fiu_almFull = 2'b00;
        chk("mid_fiu_valid", 32'(fiu_valid), 32'h0);
        chk("mid_almfull", 32'(af_almFull), 32'h3);
        chk("mid_ovf_clr", 32'(ovf_err), 32'h0);
        chk("mid_srst0", 32'(softReset_n_out), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("mid_srst", 32'(softReset_n_out), 32'(k >= 5));
            chk("mid_no_stale", 32'(fiu_valid), 32'h0);
        end

        // Full FIFO with simultaneous push and pop on ch1
        got = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            fiu_almFull = (cyc < 18) ? 2'b10 : 2'b00;
            if (cyc < 20) begin
                af_valid = 2'b10; af_data[31:16] = 16'(16'h0400 + cyc);
            end else begin
                af_valid = '0;
            end
            tick();
            if (fiu_valid[1]) begin
                chk("fpp_data", 32'(fiu_data[31:16]), 32'h0400 + 32'(got));
                got++;
            end
        end
        chk("fpp_count", 32'(got), 32'd20);
        chk("fpp_ovf", 32'(ovf_err), 32'h0);

        // Rx: exactly two cycles of delay, back-to-back
        rx_valid_in = 1'b1; rx_data_in = 16'hBEEF;
        tick();
        chk("rx_c1_v", 32'(rx_valid_out), 32'h0);
        rx_data_in = 16'h1357;
        tick();
        chk("rx_c2_v", 32'(rx_valid_out), 32'h1);
        chk("rx_c2_d", 32'(rx_data_out), 32'hBEEF);
        rx_valid_in = 1'b0;
        tick();
        chk("rx_c3_v", 32'(rx_valid_out), 32'h1);
        chk("rx_c3_d", 32'(rx_data_out), 32'h1357);
        tick();
        chk("rx_c4_v", 32'(rx_valid_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
